// File: rtl/ahb_bus_arbiter_if.sv
// Two-master AHB arbiter bundle: master-side request/bus signals, muxed slave bus
// and broadcast slave response. The slave modport is the arbiter's view.
interface ahb_bus_arbiter_if #(
    parameter int unsigned BUSA_WIDTH = 24,
    parameter int unsigned BUSD_WIDTH = 8
);
    logic                  m0_hbusreq;
    logic                  m1_hbusreq;
    logic [BUSA_WIDTH-1:0] m0_haddr;
    logic [BUSA_WIDTH-1:0] m1_haddr;
    logic                  m0_hwrite;
    logic                  m1_hwrite;
    logic [2:0]            m0_hburst;
    logic [2:0]            m1_hburst;
    logic [1:0]            m0_htrans;
    logic [1:0]            m1_htrans;
    logic [BUSD_WIDTH-1:0] m0_hwdata;
    logic [BUSD_WIDTH-1:0] m1_hwdata;
    logic                  m0_hgrant;
    logic                  m1_hgrant;

    logic [BUSA_WIDTH-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hburst;
    logic [1:0]            htrans;
    logic [BUSD_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hresp;
    logic [BUSD_WIDTH-1:0] hrdata;

    logic                  m0_hready;
    logic                  m1_hready;
    logic                  m0_hresp;
    logic                  m1_hresp;
    logic [BUSD_WIDTH-1:0] m0_hrdata;
    logic [BUSD_WIDTH-1:0] m1_hrdata;

    modport slave (
        input  m0_hbusreq, m1_hbusreq, m0_haddr, m1_haddr, m0_hwrite, m1_hwrite,
               m0_hburst, m1_hburst, m0_htrans, m1_htrans, m0_hwdata, m1_hwdata,
               hready, hresp, hrdata,
        output m0_hgrant, m1_hgrant, haddr, hwrite, hburst, htrans, hwdata,
               m0_hready, m1_hready, m0_hresp, m1_hresp, m0_hrdata, m1_hrdata
    );

    modport master (
        output m0_hbusreq, m1_hbusreq, m0_haddr, m1_haddr, m0_hwrite, m1_hwrite,
               m0_hburst, m1_hburst, m0_htrans, m1_htrans, m0_hwdata, m1_hwdata,
               hready, hresp, hrdata,
        input  m0_hgrant, m1_hgrant, haddr, hwrite, hburst, htrans, hwdata,
               m0_hready, m1_hready, m0_hresp, m1_hresp, m0_hrdata, m1_hrdata
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB bus arbiter: burst-aware grant (round-robin or fixed priority),
// address/data-phase ownership tracking and slave bus muxing.
module ahb_bus_arbiter #(
    parameter int unsigned BUSA_WIDTH = 24,
    parameter int unsigned BUSD_WIDTH = 8,
    parameter int unsigned RR         = 1
) (
    input logic               clk,
    input logic               rst_n,
    ahb_bus_arbiter_if.slave  ahb
);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_INCR   = 3'b001;

    logic             r_g;
    logic             r_aown;
    logic             r_down;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ilock;

    logic             w_g_nxt;
    logic             w_aown_nxt;
    logic             w_down_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ilock_nxt;

    logic [BUSA_WIDTH-1:0] w_haddr;
    logic [BUSD_WIDTH-1:0] w_hwdata;
    logic [1:0]            w_htrans;
    logic [2:0]            w_hburst;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g     <= 1'b0;
            r_aown  <= 1'b0;
            r_down  <= 1'b0;
            r_cnt   <= '0;
            r_ilock <= 1'b0;
        end else begin
            r_g     <= w_g_nxt;
            r_aown  <= w_aown_nxt;
            r_down  <= w_down_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ilock <= w_ilock_nxt;
        end
    end

    // next state: beat accounting, then arbitrate only between bursts
    always_comb begin
        w_g_nxt     = r_g;
        w_aown_nxt  = r_aown;
        w_down_nxt  = r_down;
        w_cnt_nxt   = r_cnt;
        w_ilock_nxt = r_ilock;
        if (ahb.hready) begin
            w_aown_nxt = r_g;
            w_down_nxt = r_aown;
            if (ahb.hresp) begin
                w_cnt_nxt   = '0;
                w_ilock_nxt = 1'b0;
            end else begin
                case (w_htrans)
                    HT_NONSEQ: begin
                        // hburst[2:1] selects 1/4/8/16 beats for both WRAP and INCR
                        case (w_hburst[2:1])
                            2'b00:   w_cnt_nxt = CNT_W'(0);
                            2'b01:   w_cnt_nxt = CNT_W'(3);
                            2'b10:   w_cnt_nxt = CNT_W'(7);
                            default: w_cnt_nxt = CNT_W'(15);
                        endcase
                        w_ilock_nxt = (w_hburst == HB_INCR);
                    end
                    HT_SEQ: begin
                        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                    HT_IDLE: w_ilock_nxt = 1'b0;
                    default: ;
                endcase
            end
            if ((w_cnt_nxt == '0) && !w_ilock_nxt) begin
                if (RR != 0) begin
                    if (r_g ? ahb.m0_hbusreq : ahb.m1_hbusreq) w_g_nxt = ~r_g;
                end else if (ahb.m0_hbusreq) begin
                    w_g_nxt = 1'b0;
                end else if (ahb.m1_hbusreq) begin
                    w_g_nxt = 1'b1;
                end
            end
        end
    end

    // outputs: grant decode, phase-owner muxes, response broadcast
    always_comb begin
        w_htrans  = r_aown ? ahb.m1_htrans : ahb.m0_htrans;
        w_hburst  = r_aown ? ahb.m1_hburst : ahb.m0_hburst;
        w_haddr   = r_aown ? ahb.m1_haddr  : ahb.m0_haddr;
        w_hwdata  = r_down ? ahb.m1_hwdata : ahb.m0_hwdata;

        ahb.m0_hgrant = ~r_g;
        ahb.m1_hgrant = r_g;
        ahb.haddr     = w_haddr;
        ahb.hwrite    = r_aown ? ahb.m1_hwrite : ahb.m0_hwrite;
        ahb.hburst    = w_hburst;
        ahb.htrans    = w_htrans;
        ahb.hwdata    = w_hwdata;
        ahb.m0_hready = ahb.hready;
        ahb.m1_hready = ahb.hready;
        ahb.m0_hresp  = ahb.hresp;
        ahb.m1_hresp  = ahb.hresp;
        ahb.m0_hrdata = ahb.hrdata;
        ahb.m1_hrdata = ahb.hrdata;
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a round-robin and a fixed-priority instance
// see identical master/slave stimulus.
module tb_ahb_bus_arbiter;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 8;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [AW-1:0] A0 = 24'h000A00;
    localparam logic [AW-1:0] A1 = 24'h000B00;
    localparam logic [DW-1:0] D0 = 8'hA0;
    localparam logic [DW-1:0] D1 = 8'hB0;
    localparam logic [DW-1:0] RD = 8'h5C;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ahb_bus_arbiter_if #(.BUSA_WIDTH(AW), .BUSD_WIDTH(DW)) bus_rr ();
    ahb_bus_arbiter_if #(.BUSA_WIDTH(AW), .BUSD_WIDTH(DW)) bus_fp ();

    ahb_bus_arbiter #(.BUSA_WIDTH(AW), .BUSD_WIDTH(DW), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .ahb(bus_rr)
    );
    ahb_bus_arbiter #(.BUSA_WIDTH(AW), .BUSD_WIDTH(DW), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .ahb(bus_fp)
    );

    // fixed-priority instance mirrors the stimulus driven into the round-robin one
    assign {bus_fp.m0_hbusreq, bus_fp.m0_haddr, bus_fp.m0_hwrite, bus_fp.m0_hburst,
            bus_fp.m0_htrans, bus_fp.m0_hwdata, bus_fp.m1_hbusreq, bus_fp.m1_haddr,
            bus_fp.m1_hwrite, bus_fp.m1_hburst, bus_fp.m1_htrans, bus_fp.m1_hwdata,
            bus_fp.hready, bus_fp.hresp, bus_fp.hrdata}
         = {bus_rr.m0_hbusreq, bus_rr.m0_haddr, bus_rr.m0_hwrite, bus_rr.m0_hburst,
            bus_rr.m0_htrans, bus_rr.m0_hwdata, bus_rr.m1_hbusreq, bus_rr.m1_haddr,
            bus_rr.m1_hwrite, bus_rr.m1_hburst, bus_rr.m1_htrans, bus_rr.m1_hwdata,
            bus_rr.hready, bus_rr.hresp, bus_rr.hrdata};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        bus_rr.m0_hbusreq = 1'b0;  bus_rr.m1_hbusreq = 1'b0;
        bus_rr.m0_haddr   = A0;    bus_rr.m1_haddr   = A1;
        bus_rr.m0_hwrite  = 1'b0;  bus_rr.m1_hwrite  = 1'b1;
        bus_rr.m0_hburst  = 3'b000; bus_rr.m1_hburst = 3'b000;
        bus_rr.m0_htrans  = IDLE;  bus_rr.m1_htrans  = IDLE;
        bus_rr.m0_hwdata  = D0;    bus_rr.m1_hwdata  = D1;
        bus_rr.hready     = 1'b1;  bus_rr.hresp      = 1'b0;
        bus_rr.hrdata     = RD;
    endtask

    // pulse reset between clock edges; caller sits just after a rising edge
    task automatic do_reset;
        idle_all();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_all();
        #3;
        checks++; if (bus_rr.m0_hgrant !== 1'b1) begin failures++; $display("FAIL reset_m0_hgrant: got %b want 1", bus_rr.m0_hgrant); end
        checks++; if (bus_rr.m1_hgrant !== 1'b0) begin failures++; $display("FAIL reset_m1_hgrant: got %b want 0", bus_rr.m1_hgrant); end
        checks++; if (bus_rr.haddr !== A0) begin failures++; $display("FAIL reset_haddr: got %h want %h", bus_rr.haddr, A0); end
        checks++; if (bus_rr.hwdata !== D0) begin failures++; $display("FAIL reset_hwdata: got %h want %h", bus_rr.hwdata, D0); end
        checks++; if (bus_rr.m1_hrdata !== RD) begin failures++; $display("FAIL reset_hrdata_bcast: got %h want %h", bus_rr.m1_hrdata, RD); end
        bus_rr.m1_hbusreq = 1'b1;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b0) begin failures++; $display("FAIL reset_held_grant: got %b want 0", bus_rr.m1_hgrant); end
        rst_n = 1'b1;
    endtask

    task automatic test_grant_idle;
        do_reset();
        bus_rr.m1_hbusreq = 1'b1;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b1) begin failures++; $display("FAIL idle_grant_e1: got %b want 1", bus_rr.m1_hgrant); end
        checks++; if (bus_fp.m1_hgrant !== 1'b1) begin failures++; $display("FAIL idle_grant_fp_e1: got %b want 1", bus_fp.m1_hgrant); end
        checks++; if (bus_rr.haddr !== A0) begin failures++; $display("FAIL idle_haddr_e1: got %h want %h", bus_rr.haddr, A0); end
        tick();
        checks++; if (bus_rr.haddr !== A1) begin failures++; $display("FAIL idle_haddr_e2: got %h want %h", bus_rr.haddr, A1); end
        checks++; if (bus_rr.hwrite !== 1'b1) begin failures++; $display("FAIL idle_hwrite_e2: got %b want 1", bus_rr.hwrite); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_rr.m1_hgrant !== 1'b0) begin failures++; $display("FAIL async_rst_grant: got %b want 0", bus_rr.m1_hgrant); end
        checks++; if (bus_rr.haddr !== A0) begin failures++; $display("FAIL async_rst_haddr: got %h want %h", bus_rr.haddr, A0); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_abort;
        do_reset();
        bus_rr.m1_hbusreq = 1'b1;
        bus_rr.m0_htrans  = NONSEQ;
        bus_rr.m0_hburst  = 3'b101;
        tick();
        bus_rr.m0_htrans = SEQ;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b0) begin failures++; $display("FAIL abort_midburst: got %b want 0", bus_rr.m1_hgrant); end
        rst_n = 1'b0;
        #2;
        bus_rr.m0_htrans = IDLE;
        rst_n = 1'b1;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b1) begin failures++; $display("FAIL abort_post_reset: got %b want 1", bus_rr.m1_hgrant); end
    endtask

    task automatic test_burst_incr4;
        logic exp;
        do_reset();
        bus_rr.m0_hbusreq = 1'b1;
        bus_rr.m1_hbusreq = 1'b1;
        bus_rr.m0_htrans  = NONSEQ;
        bus_rr.m0_hburst  = 3'b011;
        for (int b = 1; b <= 4; b++) begin
            tick();
            bus_rr.m0_htrans = (b == 4) ? IDLE : SEQ;
            exp = (b == 4);
            checks++; if (bus_rr.m1_hgrant !== exp) begin failures++; $display("FAIL incr4_grant_beat%0d: got %b want %b", b, bus_rr.m1_hgrant, exp); end
        end
        checks++; if (bus_fp.m0_hgrant !== 1'b1) begin failures++; $display("FAIL incr4_fp_keep: got %b want 1", bus_fp.m0_hgrant); end
        tick();
        checks++; if (bus_rr.haddr !== A1) begin failures++; $display("FAIL incr4_handover_haddr: got %h want %h", bus_rr.haddr, A1); end
        checks++; if (bus_rr.hwdata !== D0) begin failures++; $display("FAIL incr4_handover_hwdata: got %h want %h", bus_rr.hwdata, D0); end
        tick();
        checks++; if (bus_rr.hwdata !== D1) begin failures++; $display("FAIL incr4_new_hwdata: got %h want %h", bus_rr.hwdata, D1); end
    endtask

    task automatic test_wait_states;
        logic exp;
        do_reset();
        bus_rr.m0_hbusreq = 1'b1;
        bus_rr.m1_hbusreq = 1'b1;
        bus_rr.m0_htrans  = NONSEQ;
        bus_rr.m0_hburst  = 3'b011;
        for (int e = 0; e < 6; e++) begin
            bus_rr.hready = !(e == 1 || e == 2);
            tick();
            bus_rr.m0_htrans = (e == 5) ? IDLE : SEQ;
            exp = (e == 5);
            checks++; if (bus_rr.m1_hgrant !== exp) begin failures++; $display("FAIL wait_grant_e%0d: got %b want %b", e + 1, bus_rr.m1_hgrant, exp); end
            checks++; if (bus_rr.hwdata !== D0) begin failures++; $display("FAIL wait_hwdata_e%0d: got %h want %h", e + 1, bus_rr.hwdata, D0); end
        end
        bus_rr.hready = 1'b1;
        tick();
        checks++; if (bus_rr.hwdata !== D0) begin failures++; $display("FAIL wait_hwdata_e7: got %h want %h", bus_rr.hwdata, D0); end
        tick();
        checks++; if (bus_rr.hwdata !== D1) begin failures++; $display("FAIL wait_hwdata_e8: got %h want %h", bus_rr.hwdata, D1); end
    endtask

    task automatic test_incr_lock;
        logic [1:0] tr [9];
        logic       exp;
        tr = '{NONSEQ, SEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, IDLE};
        do_reset();
        bus_rr.m1_hbusreq = 1'b1;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b1) begin failures++; $display("FAIL lock_initial_grant: got %b want 1", bus_rr.m1_hgrant); end
        bus_rr.m1_htrans = tr[0];
        bus_rr.m1_hburst = 3'b001;
        tick();
        checks++; if (bus_rr.haddr !== A1) begin failures++; $display("FAIL lock_owner_haddr: got %h want %h", bus_rr.haddr, A1); end
        bus_rr.m0_hbusreq = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus_rr.m1_htrans = tr[i];
            tick();
            exp = (i == 8);
            checks++; if (bus_rr.m0_hgrant !== exp) begin failures++; $display("FAIL lock_rr_beat%0d: got %b want %b", i, bus_rr.m0_hgrant, exp); end
            checks++; if (bus_fp.m0_hgrant !== exp) begin failures++; $display("FAIL lock_fp_beat%0d: got %b want %b", i, bus_fp.m0_hgrant, exp); end
        end
    endtask

    task automatic test_priority;
        logic            exp_g;
        logic [AW-1:0]   exp_a;
        do_reset();
        bus_rr.m0_hbusreq = 1'b1;
        bus_rr.m1_hbusreq = 1'b1;
        bus_rr.m0_htrans  = NONSEQ;
        bus_rr.m1_htrans  = NONSEQ;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_g = ((k % 2) == 1);
            exp_a = ((k % 2) == 0) ? A1 : A0;
            checks++; if (bus_rr.m1_hgrant !== exp_g) begin failures++; $display("FAIL rr_alt_grant_e%0d: got %b want %b", k, bus_rr.m1_hgrant, exp_g); end
            checks++; if (bus_rr.haddr !== exp_a) begin failures++; $display("FAIL rr_alt_haddr_e%0d: got %h want %h", k, bus_rr.haddr, exp_a); end
            checks++; if (bus_fp.m0_hgrant !== 1'b1) begin failures++; $display("FAIL fp_keep_grant_e%0d: got %b want 1", k, bus_fp.m0_hgrant); end
        end
    endtask

    task automatic test_error;
        do_reset();
        bus_rr.m1_hbusreq = 1'b1;
        bus_rr.m0_htrans  = NONSEQ;
        bus_rr.m0_hburst  = 3'b101;
        tick();
        bus_rr.m0_htrans = SEQ;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b0) begin failures++; $display("FAIL err_beat2_grant: got %b want 0", bus_rr.m1_hgrant); end
        bus_rr.hready = 1'b0;
        bus_rr.hresp  = 1'b1;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b0) begin failures++; $display("FAIL err_first_cycle_grant: got %b want 0", bus_rr.m1_hgrant); end
        checks++; if (bus_rr.m0_hready !== 1'b0) begin failures++; $display("FAIL err_hready_bcast: got %b want 0", bus_rr.m0_hready); end
        checks++; if (bus_rr.m1_hresp !== 1'b1) begin failures++; $display("FAIL err_hresp_bcast: got %b want 1", bus_rr.m1_hresp); end
        bus_rr.hready = 1'b1;
        tick();
        checks++; if (bus_rr.m1_hgrant !== 1'b1) begin failures++; $display("FAIL err_final_grant: got %b want 1", bus_rr.m1_hgrant); end
        checks++; if (bus_fp.m1_hgrant !== 1'b1) begin failures++; $display("FAIL err_final_grant_fp: got %b want 1", bus_fp.m1_hgrant); end
        bus_rr.hresp     = 1'b0;
        bus_rr.m0_htrans = IDLE;
        tick();
        checks++; if (bus_rr.haddr !== A1) begin failures++; $display("FAIL err_new_owner_haddr: got %h want %h", bus_rr.haddr, A1); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_grant_idle();
        test_abort();
        test_burst_incr4();
        test_wait_states();
        test_incr_lock();
        test_priority();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
